hdlc_tx_frame_ctrl: RTL and testbench

HDLC_TX_FRAME_CTRL -- requirements
Module: hdlc_tx_frame_ctrl

---
 rtl/hdlc_tx_frame_ctrl_if.sv | 52 +++++
 rtl/hdlc_tx_frame_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_hdlc_tx_frame_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hdlc_tx_frame_ctrl_if.sv
// hdlc_tx_frame_ctrl_if
//   Signal bundle between the HDLC transmit frame controller and its
//   neighbours (register interface, Tx buffer, bit channel, FCS generator).
//
//   modport master : register/bit-channel side; drives the requests and
//                    observes the controller outputs.
//   modport slave  : the frame controller itself.
//
//   Tx_Enable       start-frame pulse
//   Tx_AbortFrame   abort request pulse
//   Tx_FrameSize    data bytes in the Tx buffer
//   Tx_NewByte      bit channel finished the current byte slot
//   Tx_ValidFrame   frame in progress (start flag .. end flag)
//   Tx_SendFlag     bit channel sends 0x7E
//   Tx_SendAbort    bit channel sends abort pattern
//   Tx_InitZero     pulse, clear zero-insertion counter
//   Tx_RdBuff       pulse, pop next byte from Tx buffer
//   Tx_StartFCS     pulse, initialise FCS generator
//   Tx_WriteFCS     bit channel sends FCS bytes
//   Tx_Done         controller idle, buffer consumed
//   Tx_AbortedTrans sticky, last frame was aborted
//   Tx_ByteCnt      data bytes popped in the current frame
interface hdlc_tx_frame_ctrl_if;
    logic       Tx_Enable;
    logic       Tx_AbortFrame;
    logic [7:0] Tx_FrameSize;
    logic       Tx_NewByte;
    logic       Tx_ValidFrame;
    logic       Tx_SendFlag;
    logic       Tx_SendAbort;
    logic       Tx_InitZero;
    logic       Tx_RdBuff;
    logic       Tx_StartFCS;
    logic       Tx_WriteFCS;
    logic       Tx_Done;
    logic       Tx_AbortedTrans;
    logic [7:0] Tx_ByteCnt;

    modport master (
        output Tx_Enable, Tx_AbortFrame, Tx_FrameSize, Tx_NewByte,
        input  Tx_ValidFrame, Tx_SendFlag, Tx_SendAbort, Tx_InitZero,
               Tx_RdBuff, Tx_StartFCS, Tx_WriteFCS, Tx_Done,
               Tx_AbortedTrans, Tx_ByteCnt
    );

    modport slave (
        input  Tx_Enable, Tx_AbortFrame, Tx_FrameSize, Tx_NewByte,
        output Tx_ValidFrame, Tx_SendFlag, Tx_SendAbort, Tx_InitZero,
               Tx_RdBuff, Tx_StartFCS, Tx_WriteFCS, Tx_Done,
               Tx_AbortedTrans, Tx_ByteCnt
    );
endinterface

// File: rtl/hdlc_tx_frame_ctrl.sv
// hdlc_tx_frame_ctrl
//   HDLC transmit frame sequencer: start flag, data bytes popped from the
//   Tx buffer, optional two FCS bytes, end flag; or an abort sequence.
//   All outputs are registered.
//
//   Ports:
//     Clk  rising-edge system clock
//     Rst  asynchronous active-low reset
//     bus  hdlc_tx_frame_ctrl_if.slave (see interface file for signals)
//
//   Build option:
//     HDLC_TX_FCS_EN  defined   -> FCS state present, Tx_StartFCS/Tx_WriteFCS live
//                     undefined -> last data byte goes straight to the end
//                                  flag, Tx_StartFCS/Tx_WriteFCS tied 0
module hdlc_tx_frame_ctrl (
    input logic                 Clk,
    input logic                 Rst,
    hdlc_tx_frame_ctrl_if.slave bus
);
    localparam logic [7:0] MAX_SIZE = 8'd126;

    // Encodings kept identical in both builds.
`ifdef HDLC_TX_FCS_EN
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_FLAG = 3'd1,
        DATA       = 3'd2,
        FCS        = 3'd3,
        END_FLAG   = 3'd4,
        ABORT      = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_FLAG = 3'd1,
        DATA       = 3'd2,
        END_FLAG   = 3'd4,
        ABORT      = 3'd5
    } state_t;
`endif

    state_t     state;
    logic [7:0] size_q;
    logic [7:0] byte_cnt;
    logic       valid_frame;
    logic       send_flag;
    logic       send_abort;
    logic       init_zero;
    logic       rd_buff;
    logic       done;
    logic       aborted;
`ifdef HDLC_TX_FCS_EN
    logic       start_fcs;
    logic       write_fcs;
    logic       fcs_cnt;    // set once the first FCS byte slot is done
`endif

    logic size_ok;
    logic abort_req;

    assign size_ok   = (bus.Tx_FrameSize != 8'd0) && (bus.Tx_FrameSize <= MAX_SIZE);
    // Abort only means something while a frame is on the line.
    assign abort_req = bus.Tx_AbortFrame && (state != IDLE) && (state != ABORT);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state       <= IDLE;
            size_q      <= 8'd0;
            byte_cnt    <= 8'd0;
            valid_frame <= 1'b0;
            send_flag   <= 1'b0;
            send_abort  <= 1'b0;
            init_zero   <= 1'b0;
            rd_buff     <= 1'b0;
            done        <= 1'b1;
            aborted     <= 1'b0;
`ifdef HDLC_TX_FCS_EN
            start_fcs   <= 1'b0;
            write_fcs   <= 1'b0;
            fcs_cnt     <= 1'b0;
`endif
        end else begin
            // one-cycle pulses
            init_zero <= 1'b0;
            rd_buff   <= 1'b0;
`ifdef HDLC_TX_FCS_EN
            start_fcs <= 1'b0;
`endif
            // Abort wins over a coincident NewByte: no pop, no count change.
            if (abort_req) begin
                state      <= ABORT;
                send_abort <= 1'b1;
                aborted    <= 1'b1;
                send_flag  <= 1'b0;
`ifdef HDLC_TX_FCS_EN
                write_fcs  <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.Tx_Enable && size_ok) begin
                            state       <= START_FLAG;
                            size_q      <= bus.Tx_FrameSize;
                            valid_frame <= 1'b1;
                            send_flag   <= 1'b1;
                            done        <= 1'b0;
                            init_zero   <= 1'b1;
                            aborted     <= 1'b0;
                            byte_cnt    <= 8'd0;
                        end
                    end
                    START_FLAG: begin
                        if (bus.Tx_NewByte) begin
                            state     <= DATA;
                            send_flag <= 1'b0;
                            rd_buff   <= 1'b1;
                            byte_cnt  <= 8'd1;
`ifdef HDLC_TX_FCS_EN
                            start_fcs <= 1'b1;
`endif
                        end
                    end
                    DATA: begin
                        if (bus.Tx_NewByte) begin
                            if (byte_cnt < size_q) begin
                                rd_buff  <= 1'b1;
                                byte_cnt <= byte_cnt + 8'd1;
                            end else begin
`ifdef HDLC_TX_FCS_EN
                                state     <= FCS;
                                write_fcs <= 1'b1;
                                fcs_cnt   <= 1'b0;
`else
                                state     <= END_FLAG;
                                send_flag <= 1'b1;
`endif
                            end
                        end
                    end
`ifdef HDLC_TX_FCS_EN
                    FCS: begin
                        // two byte slots of FCS, then the closing flag
                        if (bus.Tx_NewByte) begin
                            if (fcs_cnt) begin
                                state     <= END_FLAG;
                                write_fcs <= 1'b0;
                                send_flag <= 1'b1;
                            end else begin
                                fcs_cnt <= 1'b1;
                            end
                        end
                    end
`endif
                    END_FLAG: begin
                        if (bus.Tx_NewByte) begin
                            state       <= IDLE;
                            send_flag   <= 1'b0;
                            valid_frame <= 1'b0;
                            done        <= 1'b1;
                        end
                    end
                    ABORT: begin
                        if (bus.Tx_NewByte) begin
                            state       <= IDLE;
                            send_abort  <= 1'b0;
                            valid_frame <= 1'b0;
                            done        <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.Tx_ValidFrame   = valid_frame;
    assign bus.Tx_SendFlag     = send_flag;
    assign bus.Tx_SendAbort    = send_abort;
    assign bus.Tx_InitZero     = init_zero;
    assign bus.Tx_RdBuff       = rd_buff;
    assign bus.Tx_Done         = done;
    assign bus.Tx_AbortedTrans = aborted;
    assign bus.Tx_ByteCnt      = byte_cnt;
`ifdef HDLC_TX_FCS_EN
    assign bus.Tx_StartFCS     = start_fcs;
    assign bus.Tx_WriteFCS     = write_fcs;
`else
    assign bus.Tx_StartFCS     = 1'b0;
    assign bus.Tx_WriteFCS     = 1'b0;
`endif
endmodule

// File: tb/tb_hdlc_tx_frame_ctrl.sv
// tb_hdlc_tx_frame_ctrl
//   Directed stimulus; every expected change of the DUT output vector is
//   queued before the stimulus that causes it, and a negedge monitor pops
//   and compares each time the observed output vector changes.
module tb_hdlc_tx_frame_ctrl;
    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    hdlc_tx_frame_ctrl_if bus ();

    hdlc_tx_frame_ctrl dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

`ifdef HDLC_TX_FCS_EN
    localparam logic FCS_ON = 1'b1;
`else
    localparam logic FCS_ON = 1'b0;
`endif

    typedef struct packed {
        logic       v;      // ValidFrame
        logic       sf;     // SendFlag
        logic       sa;     // SendAbort
        logic       iz;     // InitZero
        logic       rb;     // RdBuff
        logic       sfcs;   // StartFCS
        logic       wf;     // WriteFCS
        logic       d;      // Done
        logic       ab;     // AbortedTrans
        logic [7:0] cnt;    // ByteCnt
    } obs_t;

    obs_t exp_q[$];
    obs_t prev = 'x;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rd_seen = 0;
    int   ev_idx = 0;

    function automatic obs_t sample();
        obs_t o;
        o.v    = bus.Tx_ValidFrame;
        o.sf   = bus.Tx_SendFlag;
        o.sa   = bus.Tx_SendAbort;
        o.iz   = bus.Tx_InitZero;
        o.rb   = bus.Tx_RdBuff;
        o.sfcs = bus.Tx_StartFCS;
        o.wf   = bus.Tx_WriteFCS;
        o.d    = bus.Tx_Done;
        o.ab   = bus.Tx_AbortedTrans;
        o.cnt  = bus.Tx_ByteCnt;
        return o;
    endfunction

    // monitor / scoreboard
    always @(negedge Clk) begin
        obs_t cur;
        obs_t want;
        cur = sample();
        if (cur !== prev) begin
            n_cmp++;
            ev_idx++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change#%0d got=%h want=no_change (t=%0t)", ev_idx, cur, $time);
            end else begin
                want = exp_q.pop_front();
                if (cur !== want) begin
                    n_bad++;
                    $display("FAIL out_vec#%0d got=%h want=%h (t=%0t)", ev_idx, cur, want, $time);
                end
            end
        end
        prev = cur;
        if (cur.rb === 1'b1) rd_seen++;
    end

    // push an expected output vector
    task automatic e(input logic v, sf, sa, iz, rb, sfcs, wf, d, ab, input logic [7:0] cnt);
        obs_t o;
        o = '{v, sf, sa, iz, rb, sfcs, wf, d, ab, cnt};
        exp_q.push_back(o);
    endtask

    // all stimulus tasks start and end at posedge+1
    task automatic gap(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic cyc(input logic en, ab, nb);
        bus.Tx_Enable     = en;
        bus.Tx_AbortFrame = ab;
        bus.Tx_NewByte    = nb;
        @(posedge Clk);
        #1;
        bus.Tx_Enable     = 1'b0;
        bus.Tx_AbortFrame = 1'b0;
        bus.Tx_NewByte    = 1'b0;
    endtask

    task automatic nb();
        cyc(1'b0, 1'b0, 1'b1);
        gap(7);
    endtask

    task automatic reset_vec();
        e(0, 0, 0, 0, 0, 0, 0, 1, 0, 8'd0);
    endtask

    task automatic start_frame(input logic [7:0] size);
        bus.Tx_FrameSize = size;
        e(1, 1, 0, 1, 0, 0, 0, 0, 0, 8'd0);
        e(1, 1, 0, 0, 0, 0, 0, 0, 0, 8'd0);
        cyc(1'b1, 1'b0, 1'b0);
        gap(3);
    endtask

    task automatic first_byte();
        e(1, 0, 0, 0, 1, FCS_ON, 0, 0, 0, 8'd1);
        e(1, 0, 0, 0, 0, 0, 0, 0, 0, 8'd1);
        nb();
    endtask

    task automatic next_byte(input logic [7:0] n);
        e(1, 0, 0, 0, 1, 0, 0, 0, 0, n);
        e(1, 0, 0, 0, 0, 0, 0, 0, 0, n);
        nb();
    endtask

    // last data slot done -> (FCS x2) -> end flag -> idle
    task automatic finish(input logic [7:0] n);
        if (FCS_ON) begin
            e(1, 0, 0, 0, 0, 0, 1, 0, 0, n);
            nb();
            nb();   // first FCS byte: no visible change
            e(1, 1, 0, 0, 0, 0, 0, 0, 0, n);
            nb();
        end else begin
            e(1, 1, 0, 0, 0, 0, 0, 0, 0, n);
            nb();
        end
        e(0, 0, 0, 0, 0, 0, 0, 1, 0, n);
        nb();
    endtask

    initial begin
        bus.Tx_Enable     = 1'b0;
        bus.Tx_AbortFrame = 1'b0;
        bus.Tx_FrameSize  = 8'd0;
        bus.Tx_NewByte    = 1'b0;
        reset_vec();
        @(posedge Clk);
        @(posedge Clk);
        #1 Rst = 1'b1;
        gap(2);

        // size 3 full frame
        start_frame(8'd3);
        first_byte();
        next_byte(8'd2);
        next_byte(8'd3);
        finish(8'd3);

        // illegal sizes and idle abort / idle NewByte: no output change
        bus.Tx_FrameSize = 8'd0;
        cyc(1'b1, 1'b0, 1'b0);
        gap(3);
        bus.Tx_FrameSize = 8'd127;
        cyc(1'b1, 1'b0, 1'b0);
        gap(3);
        cyc(1'b0, 1'b1, 1'b0);
        gap(3);
        cyc(1'b0, 1'b0, 1'b1);
        gap(3);

        // size 5, abort after 2nd pop
        start_frame(8'd5);
        first_byte();
        next_byte(8'd2);
        e(1, 0, 1, 0, 0, 0, 0, 0, 1, 8'd2);
        cyc(1'b0, 1'b1, 1'b0);
        gap(3);
        cyc(1'b0, 1'b1, 1'b0);   // abort while already aborting: ignored
        gap(3);
        e(0, 0, 0, 0, 0, 0, 0, 1, 1, 8'd2);
        nb();
        cyc(1'b0, 1'b1, 1'b0);   // abort in idle: ignored
        gap(3);

        // size 2, abort coincident with a DATA NewByte
        start_frame(8'd2);
        first_byte();
        e(1, 0, 1, 0, 0, 0, 0, 0, 1, 8'd1);
        cyc(1'b0, 1'b1, 1'b1);
        gap(7);
        e(0, 0, 0, 0, 0, 0, 0, 1, 1, 8'd1);
        nb();

        // size 126, reset mid-DATA, then a size 1 frame right after release
        start_frame(8'd126);
        first_byte();
        next_byte(8'd2);
        next_byte(8'd3);
        reset_vec();
        #2 Rst = 1'b0;
        @(posedge Clk);
        #1 Rst = 1'b1;
        start_frame(8'd1);
        first_byte();
        finish(8'd1);

        // size 2 with extra Enables and a size change mid-frame
        start_frame(8'd2);
        bus.Tx_FrameSize = 8'd1;
        cyc(1'b1, 1'b0, 1'b0);
        gap(3);
        first_byte();
        cyc(1'b1, 1'b0, 1'b0);
        gap(3);
        next_byte(8'd2);
        finish(8'd2);

        gap(5);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events got=%0d want=0", exp_q.size());
        end
        n_cmp++;
        if (rd_seen != 12) begin
            n_bad++;
            $display("FAIL rdbuff_total got=%0d want=12", rd_seen);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
